// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
// Steps an 8:1 mux select through all channels, waits SETTLE cycles on each,
// samples the mux output and hands the 8-bit snapshot over valid/ready.
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start, continuous begin a scan from IDLE / auto-restart on completion
//   abort             drop the scan in progress, return to IDLE
//   sel, en_n         mux select (channel index) and active-low mux enable
//   mux_in            mux output
//   snap, snap_valid  snapshot (bit c = channel c) and its valid flag
//   snap_ready        consumer accepts snap
//   busy              high in every state except IDLE
//   err_overrun       sticky: a continuous-mode snapshot was dropped
//   clr_err           clears err_overrun (a coincident set wins)
module mux_scan_sequencer #(
   parameter int unsigned SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       continuous,
   input  logic       abort,
   output logic [2:0] sel,
   output logic       en_n,
   input  logic       mux_in,
   output logic [7:0] snap,
   output logic       snap_valid,
   input  logic       snap_ready,
   output logic       busy,
   output logic       err_overrun,
   input  logic       clr_err
);

   localparam int unsigned CW = 4;
   localparam int unsigned NW = 8;

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_WAIT} state_t;

   state_t          state_q, state_d;
   logic [2:0]      sel_d;
   logic            en_n_d;
   logic            busy_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [NW-1:0]   shreg_q, shreg_d;
   logic [NW-1:0]   snap_d;
   logic [NW-1:0]   load_data;
   logic            snap_valid_d;
   logic            err_d;
   logic            load;
   logic            ovr_set;
   logic            out_free;

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         sel         <= 3'd0;
         en_n        <= 1'b1;
         busy        <= 1'b0;
         cnt_q       <= '0;
         shreg_q     <= '0;
         snap        <= '0;
         snap_valid  <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel         <= sel_d;
         en_n        <= en_n_d;
         busy        <= busy_d;
         cnt_q       <= cnt_d;
         shreg_q     <= shreg_d;
         snap        <= snap_d;
         snap_valid  <= snap_valid_d;
         err_overrun <= err_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d   = state_q;
      sel_d     = sel;
      en_n_d    = en_n;
      cnt_d     = cnt_q;
      shreg_d   = shreg_q;
      load      = 1'b0;
      load_data = shreg_q;
      ovr_set   = 1'b0;
      // Snapshot register can take new data this edge
      out_free  = !snap_valid || snap_ready;

      unique case (state_q)
         S_IDLE: begin
            sel_d  = 3'd0;
            en_n_d = 1'b1;
            if (start && !abort) begin
               state_d = S_SETTLE;
               en_n_d  = 1'b0;
               cnt_d   = '0;
            end
         end
         S_SETTLE: begin
            if (abort) begin
               state_d = S_IDLE;
               sel_d   = 3'd0;
               en_n_d  = 1'b1;
               cnt_d   = '0;
            end else if (cnt_q == CW'(SETTLE - 1)) begin
               state_d = S_SAMPLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_SAMPLE: begin
            if (abort) begin
               state_d = S_IDLE;
               sel_d   = 3'd0;
               en_n_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               shreg_d[sel] = mux_in;
               cnt_d        = '0;
               if (sel != 3'd7) begin
                  state_d = S_SETTLE;
                  sel_d   = sel + 3'd1;
               end else if (out_free || continuous) begin
                  // Either deliver the scan or drop it; both may restart
                  if (out_free) begin
                     load      = 1'b1;
                     load_data = {mux_in, shreg_q[6:0]};
                  end else begin
                     ovr_set = 1'b1;
                  end
                  sel_d = 3'd0;
                  if (continuous) begin
                     state_d = S_SETTLE;
                     en_n_d  = 1'b0;
                  end else begin
                     state_d = S_IDLE;
                     en_n_d  = 1'b1;
                  end
               end else begin
                  // Hold the full scan (sel stays 7) until the consumer frees snap
                  state_d = S_WAIT;
                  en_n_d  = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (abort) begin
               state_d = S_IDLE;
               sel_d   = 3'd0;
               en_n_d  = 1'b1;
            end else if (out_free) begin
               load    = 1'b1;
               state_d = S_IDLE;
               sel_d   = 3'd0;
               en_n_d  = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            sel_d   = 3'd0;
            en_n_d  = 1'b1;
         end
      endcase

      busy_d = (state_d != S_IDLE);
      snap_d = load ? load_data : snap;

      // A load on the same edge as a transfer keeps valid high
      if (load)
         snap_valid_d = 1'b1;
      else if (snap_valid && snap_ready)
         snap_valid_d = 1'b0;
      else
         snap_valid_d = snap_valid;

      if (ovr_set)
         err_d = 1'b1;
      else if (clr_err)
         err_d = 1'b0;
      else
         err_d = err_overrun;
   end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer with a behavioural 8:1 mux model.
module tb_mux_scan_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start, continuous, abort;
   logic [2:0] sel;
   logic       en_n;
   logic       mux_in;
   logic [7:0] snap;
   logic       snap_valid, snap_ready;
   logic       busy, err_overrun, clr_err;
   logic [7:0] chan;

   int errors = 0;
   int checks = 0;

   mux_scan_sequencer #(.SETTLE(2)) dut (
      .clk(clk), .rst(rst), .start(start), .continuous(continuous), .abort(abort),
      .sel(sel), .en_n(en_n), .mux_in(mux_in), .snap(snap), .snap_valid(snap_valid),
      .snap_ready(snap_ready), .busy(busy), .err_overrun(err_overrun), .clr_err(clr_err)
   );

   // Mux model: disabled mux drives 0
   assign mux_in = en_n ? 1'b0 : chan[sel];

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start so that the next edge is E0; returns just after E0
   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 0; continuous = 0; abort = 0; snap_ready = 0; clr_err = 0;
      chan = 8'h00;
      tick(); tick();
      checks++;
      if (sel !== 3'd0 || en_n !== 1'b1 || snap !== 8'h00 || snap_valid !== 1'b0 ||
          busy !== 1'b0 || err_overrun !== 1'b0) begin
         errors++;
         $display("FAIL reset: sel=%0d en_n=%b snap=%h valid=%b busy=%b err=%b, need 0 1 00 0 0 0",
                  sel, en_n, snap, snap_valid, busy, err_overrun);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_scan();
      chan = 8'hA5;
      do_start();
      checks++;
      if (sel !== 3'd0 || en_n !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL scan_e0: sel=%0d en_n=%b busy=%b, need 0 0 1", sel, en_n, busy);
      end
      for (int k = 1; k < 24; k++) begin
         tick();
         checks++;
         if (sel !== 3'(k / 3) || en_n !== 1'b0 || snap_valid !== 1'b0) begin
            errors++;
            $display("FAIL scan_step%0d: sel=%0d en_n=%b valid=%b, need %0d 0 0",
                     k, sel, en_n, snap_valid, k / 3);
         end
      end
      tick();
      checks++;
      if (snap !== 8'hA5 || snap_valid !== 1'b1 || busy !== 1'b0 || en_n !== 1'b1 || sel !== 3'd0) begin
         errors++;
         $display("FAIL scan_done: snap=%h valid=%b busy=%b en_n=%b sel=%0d, need a5 1 0 1 0",
                  snap, snap_valid, busy, en_n, sel);
      end
   endtask

   task automatic test_hold();
      snap_ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         checks++;
         if (snap !== 8'hA5 || snap_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold%0d: snap=%h valid=%b, need a5 1", k, snap, snap_valid);
         end
      end
      snap_ready = 1'b1;
      tick();
      snap_ready = 1'b0;
      checks++;
      if (snap_valid !== 1'b0) begin
         errors++;
         $display("FAIL hold_xfer: valid=%b, need 0", snap_valid);
      end
   endtask

   task automatic test_overrun();
      continuous = 1'b1;
      chan = 8'hA5;
      do_start();
      repeat (24) tick();
      checks++;
      if (snap !== 8'hA5 || snap_valid !== 1'b1 || busy !== 1'b1 || err_overrun !== 1'b0 || en_n !== 1'b0) begin
         errors++;
         $display("FAIL cont_scan1: snap=%h valid=%b busy=%b err=%b en_n=%b, need a5 1 1 0 0",
                  snap, snap_valid, busy, err_overrun, en_n);
      end
      chan = 8'h3C;
      repeat (23) tick();
      checks++;
      if (err_overrun !== 1'b0) begin
         errors++;
         $display("FAIL cont_pre: err=%b, need 0", err_overrun);
      end
      // Clear coincides with the overrun edge: set wins
      clr_err = 1'b1;
      tick();
      checks++;
      if (err_overrun !== 1'b1 || snap !== 8'hA5 || snap_valid !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL overrun: err=%b snap=%h valid=%b busy=%b, need 1 a5 1 1",
                  err_overrun, snap, snap_valid, busy);
      end
      continuous = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      clr_err = 1'b0;
      checks++;
      if (err_overrun !== 1'b0 || busy !== 1'b0 || en_n !== 1'b1 || sel !== 3'd0 ||
          snap !== 8'hA5 || snap_valid !== 1'b1) begin
         errors++;
         $display("FAIL clr_abort: err=%b busy=%b en_n=%b sel=%0d snap=%h valid=%b, need 0 0 1 0 a5 1",
                  err_overrun, busy, en_n, sel, snap, snap_valid);
      end
   endtask

   task automatic test_wait();
      chan = 8'h5A;
      do_start();
      repeat (24) tick();
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (en_n !== 1'b1 || busy !== 1'b1 || sel !== 3'd7 || snap !== 8'hA5 || snap_valid !== 1'b1) begin
            errors++;
            $display("FAIL wait%0d: en_n=%b busy=%b sel=%0d snap=%h valid=%b, need 1 1 7 a5 1",
                     k, en_n, busy, sel, snap, snap_valid);
         end
         tick();
      end
      snap_ready = 1'b1;
      tick();
      snap_ready = 1'b0;
      checks++;
      if (snap !== 8'h5A || snap_valid !== 1'b1 || busy !== 1'b0 || sel !== 3'd0) begin
         errors++;
         $display("FAIL wait_load: snap=%h valid=%b busy=%b sel=%0d, need 5a 1 0 0",
                  snap, snap_valid, busy, sel);
      end
      snap_ready = 1'b1;
      tick();
      snap_ready = 1'b0;
      checks++;
      if (snap_valid !== 1'b0 || snap !== 8'h5A) begin
         errors++;
         $display("FAIL wait_drain: valid=%b snap=%h, need 0 5a", snap_valid, snap);
      end
   endtask

   task automatic test_abort();
      chan = 8'hFF;
      do_start();
      repeat (10) tick();
      checks++;
      if (sel !== 3'd3 || en_n !== 1'b0) begin
         errors++;
         $display("FAIL abort_pre: sel=%0d en_n=%b, need 3 0", sel, en_n);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if (sel !== 3'd0 || en_n !== 1'b1 || busy !== 1'b0 || snap_valid !== 1'b0 || snap !== 8'h5A) begin
         errors++;
         $display("FAIL abort: sel=%0d en_n=%b busy=%b valid=%b snap=%h, need 0 1 0 0 5a",
                  sel, en_n, busy, snap_valid, snap);
      end
      // start and abort together in IDLE: stay idle
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      repeat (30) tick();
      checks++;
      if (busy !== 1'b0 || snap_valid !== 1'b0 || en_n !== 1'b1) begin
         errors++;
         $display("FAIL start_abort: busy=%b valid=%b en_n=%b, need 0 0 1", busy, snap_valid, en_n);
      end
   endtask

   task automatic test_async_reset();
      chan = 8'h81;
      do_start();
      repeat (5) tick();
      #2 rst = 1'b1;
      #1;
      checks++;
      if (sel !== 3'd0 || en_n !== 1'b1 || snap !== 8'h00 || snap_valid !== 1'b0 ||
          busy !== 1'b0 || err_overrun !== 1'b0) begin
         errors++;
         $display("FAIL async_rst: sel=%0d en_n=%b snap=%h valid=%b busy=%b err=%b, need 0 1 00 0 0 0",
                  sel, en_n, snap, snap_valid, busy, err_overrun);
      end
      tick();
      rst = 1'b0;
      tick();
      do_start();
      repeat (23) tick();
      checks++;
      if (snap_valid !== 1'b0 || busy !== 1'b1 || sel !== 3'd7) begin
         errors++;
         $display("FAIL rescan_pre: valid=%b busy=%b sel=%0d, need 0 1 7", snap_valid, busy, sel);
      end
      tick();
      checks++;
      if (snap !== 8'h81 || snap_valid !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rescan: snap=%h valid=%b busy=%b, need 81 1 0", snap, snap_valid, busy);
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_hold();
      test_overrun();
      test_wait();
      test_abort();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
